// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready handshake, one-entry skid
// buffer, synchronous flush to a NOP bubble and a saturating stall counter.
module pipe_skid_stage #(
  parameter int DATA_W     = 102,
  parameter int CTRL_W     = 8,
  parameter bit CLEAR_CTRL = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  // Low CTRL_W bits set; shift-then-subtract also covers CTRL_W == DATA_W.
  localparam logic [DATA_W-1:0] CTRL_MASK = (DATA_W'(1) << CTRL_W) - DATA_W'(1);

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  // Value the main register takes when the stage becomes a bubble.
  function automatic logic [DATA_W-1:0] bubble(input logic [DATA_W-1:0] d);
    return CLEAR_CTRL ? (d & ~CTRL_MASK) : d;
  endfunction

  assign out_data = main_q;

  // in_ready/out_valid are registered alongside the state so neither depends
  // combinationally on out_ready or in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= bubble(main_q);
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state     <= FULL;
            out_valid <= 1'b1;
            main_q    <= in_data;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_q <= in_data;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              main_q    <= bubble(main_q);
            end
          end else if (in_valid) begin
            state    <= SKID;
            in_ready <= 1'b0;
            skid_q   <= in_data;
          end
        end
        SKID: begin
          if (out_ready) begin
            state    <= FULL;
            in_ready <= 1'b1;
            main_q   <= skid_q;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (control clearing on/off, 4- and
// 16-bit counters) driven in lockstep and compared against a queue model.
module tb_pipe_skid_stage;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [3:0]    stall_cnt_a;
  logic [15:0]   stall_cnt_b;

  int nvec = 0;
  int nerr = 0;

  // Reference model: FIFO of held entries plus the last value of the main
  // register (seen on out_data whenever the stage is empty).
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_a, last_b;
  int            cnt_a, cnt_b;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(8), .CLEAR_CTRL(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .stall_cnt(stall_cnt_a)
  );

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(8), .CLEAR_CTRL(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .stall_cnt(stall_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_a = '0;
    last_b = '0;
    cnt_a  = 0;
    cnt_b  = 0;
  endtask

  task automatic check_all(input string tag);
    logic          ov, ir;
    logic [DW-1:0] ea, eb;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    ea = ov ? q[0] : last_a;
    eb = ov ? q[0] : last_b;
    chk({tag, ".a.out_valid"}, 32'(out_valid_a), 32'(ov));
    chk({tag, ".a.in_ready"},  32'(in_ready_a),  32'(ir));
    chk({tag, ".a.out_data"},  32'(out_data_a),  32'(ea));
    chk({tag, ".a.stall_cnt"}, 32'(stall_cnt_a), 32'(cnt_a));
    chk({tag, ".b.out_valid"}, 32'(out_valid_b), 32'(ov));
    chk({tag, ".b.in_ready"},  32'(in_ready_b),  32'(ir));
    chk({tag, ".b.out_data"},  32'(out_data_b),  32'(eb));
    chk({tag, ".b.stall_cnt"}, 32'(stall_cnt_b), 32'(cnt_b));
  endtask

  // One clock: apply inputs, advance the model on the edge, check 1 ns later.
  task automatic step(input string tag, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    int            was;
    logic [DW-1:0] popped;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    was = q.size();
    if (fl) begin
      if (was > 0) begin
        last_a = q[0];
        last_b = q[0];
      end
      q.delete();
      last_a[7:0] = 8'h00;
    end else begin
      if (was > 0 && !ordy) begin
        cnt_a = (cnt_a == 15) ? 15 : cnt_a + 1;
        cnt_b = (cnt_b == 65535) ? 65535 : cnt_b + 1;
      end
      if (was > 0 && ordy) begin
        popped = q.pop_front();
        last_a = popped;
        last_b = popped;
      end
      if (iv && was < 2) q.push_back(d);
      if (was > 0 && q.size() == 0) last_a[7:0] = 8'h00;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Streaming at full rate
    step("stream1", 1'b1, 16'd1, 1'b1, 1'b0);
    step("stream2", 1'b1, 16'd2, 1'b1, 1'b0);
    step("stream3", 1'b1, 16'd3, 1'b1, 1'b0);
    step("stream4", 1'b1, 16'd4, 1'b1, 1'b0);
    step("stream_drain", 1'b0, 16'd0, 1'b1, 1'b0);

    // Back-pressure into the skid entry, then drain in order
    step("bp_fill", 1'b1, 16'h000A, 1'b1, 1'b0);
    step("bp_skid", 1'b1, 16'h000B, 1'b0, 1'b0);
    step("bp_hold", 1'b1, 16'h000B, 1'b0, 1'b0);
    step("bp_out_a", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("bp_out_b", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush while in SKID: the skid entry must never appear
    step("fl_fill", 1'b1, 16'h120A, 1'b1, 1'b0);
    step("fl_skid", 1'b1, 16'h340B, 1'b0, 1'b0);
    step("fl_flush", 1'b1, 16'h5555, 1'b1, 1'b1);
    step("fl_after", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Stall counter saturation (4-bit instance)
    step("sat_fill", 1'b1, 16'h7777, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("sat_stall", 1'b0, 16'h0000, 1'b0, 1'b0);
    step("sat_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset between edges while in SKID
    step("ar_fill", 1'b1, 16'hABCD, 1'b1, 1'b0);
    step("ar_skid", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #2;
    rst_n = 1'b1;

    // Drain a stage holding 0xFF: clearing instance shows 0x00, other keeps 0xFF
    step("drain_fill", 1'b1, 16'h00FF, 1'b1, 1'b0);
    step("drain_empty", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
